// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states and
// the opcode legality check.
package alu_defs;

  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_FUNC = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADDC, OP_ADD, OP_SUB, OP_NAND, OP_OR,
      OP_XOR, OP_NOT, OP_SRL, OP_FUNC: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// Instruction FIFO: wrapping read/write pointers plus an occupancy count.
// Callers never push when full or pop when empty.
module alu_instr_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int EW    = 4 + 2 * WIDTH + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] wdata_i,
  output logic [EW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the external 4-bit ALU: queues instructions, drives the
// ALU input registers, captures results into acc/flags and hands them out.
module alu_issue_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_acc,
  input  logic             in_use_c,
  output logic [WIDTH-1:0] aluin_a,
  output logic [WIDTH-1:0] aluin_b,
  output logic [3:0]       OPCODE,
  output logic             Cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             Cout,
  input  logic             OF,
  output logic [WIDTH-1:0] acc,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             zero_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a valid side holds its payload stable until that edge.
  localparam int EW = 4 + 2 * WIDTH + 2;

  state_t state_q, state_d;
  logic   push, pop, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_wdata, fifo_rdata;

  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_a_acc, head_use_c;

  logic [WIDTH-1:0] aluin_a_q, aluin_a_d, aluin_b_q, aluin_b_d, acc_q, acc_d;
  logic [3:0]       opcode_q, opcode_d;
  logic cin_q, cin_d, carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic res_valid_q, res_valid_d, res_err_q, res_err_d;

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign fifo_wdata = {in_opcode, in_a, in_b, in_a_acc, in_use_c};
  assign {head_op, head_a, head_b, head_a_acc, head_use_c} = fifo_rdata;

  alu_instr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT: begin
        if (res_ready) begin
          if (fifo_empty) begin
            state_d = ST_IDLE;
          end else begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // acc is read at pop time, after any earlier capture, so chained ops see it.
  always_comb begin
    aluin_a_d   = aluin_a_q;
    aluin_b_d   = aluin_b_q;
    opcode_d    = opcode_q;
    cin_d       = cin_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    res_err_d   = res_err_q;
    res_valid_d = (state_d == ST_CAPT);
    if (pop) begin
      aluin_a_d = head_a_acc ? acc_q : head_a;
      aluin_b_d = head_b;
      opcode_d  = head_op;
      cin_d     = head_use_c & carry_q;
    end
    if (state_q == ST_ISSUE) begin
      res_err_d = !op_legal(opcode_q);
      if (op_legal(opcode_q)) begin
        acc_d   = alu_out;
        carry_d = Cout;
        ovf_d   = OF;
        zero_d  = (alu_out == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      aluin_a_q   <= '0;
      aluin_b_q   <= '0;
      opcode_q    <= '0;
      cin_q       <= 1'b0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aluin_a_q   <= aluin_a_d;
      aluin_b_q   <= aluin_b_d;
      opcode_q    <= opcode_d;
      cin_q       <= cin_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
    end
  end

  assign aluin_a    = aluin_a_q;
  assign aluin_b    = aluin_b_q;
  assign OPCODE     = opcode_q;
  assign Cin        = cin_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;
  assign zero_flag  = zero_q;
  assign res_valid  = res_valid_q;
  assign res_err    = res_err_q;
  assign dbg_state  = state_q;

endmodule
